oam_dma_arbiter: RTL

//  Arbitrates the single CPU memory bus between the 6502 CPU core and the NES sprite
//  (OAM) DMA engine. A CPU write to the DMA register stalls the CPU via its stall

---
 rtl/oam_dma_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU bus between the 6502 core and the sprite DMA engine. It passes CPU strobes through while idle.
// A write to the DMA register stalls the CPU and copies one page to the OAM data port.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic        cpu_stall_o,
    output logic [15:0] bus_addr_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    output logic [7:0]  bus_wdata_o,
    input  logic [7:0]  bus_rdata_i,
    output logic        dma_active_o
);

    localparam int CNT_W = $clog2(XFER_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t           state_q;
    logic [7:0]       page_q;
    logic [CNT_W-1:0] cnt_q;
    logic             parity_q;
    logic             stall_q;

    logic             trigger_d;
    logic             cnt_last_d;
    logic [15:0]      dma_addr_d;

    always_comb begin
        trigger_d  = (state_q == IDLE) && cpu_write_i &&
                     (cpu_addr_i == DMA_REG_ADDR) && !stall_q;
        cnt_last_d = (cnt_q == CNT_W'(XFER_LEN - 1));
        // Count sits in the low byte; the page never carries out past bit 15.
        dma_addr_d = {page_q, 8'(cnt_q)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            parity_q <= ~parity_q;
            case (state_q)
                IDLE: begin
                    if (trigger_d) begin
                        page_q  <= cpu_wdata_i;
                        cnt_q   <= '0;
                        state_q <= HALT;
                        stall_q <= 1'b1;
                    end
                end
                // An odd cycle at HALT costs one extra alignment cycle before the first read.
                HALT:  state_q <= parity_q ? ALIGN : READ;
                ALIGN: state_q <= READ;
                READ:  state_q <= WRITE;
                WRITE: begin
                    if (cnt_last_d) begin
                        state_q <= IDLE;
                        stall_q <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= READ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus_addr_o  = dma_addr_d;
        bus_read_o  = 1'b0;
        bus_write_o = 1'b0;
        bus_wdata_o = 8'h00;
        case (state_q)
            IDLE: begin
                bus_addr_o  = cpu_addr_i;
                bus_read_o  = cpu_read_i;
                bus_write_o = cpu_write_i;
                bus_wdata_o = cpu_wdata_i;
            end
            READ:  bus_read_o = 1'b1;
            WRITE: begin
                bus_write_o = 1'b1;
                bus_addr_o  = OAM_DATA_ADDR;
                bus_wdata_o = bus_rdata_i;
            end
            default: ;
        endcase
    end

    assign cpu_stall_o  = stall_q;
    assign dma_active_o = stall_q;

endmodule
